// File: rtl/axi_ohs_pwm_l1_ctrl_if.sv
// rtl/axi_ohs_pwm_l1_ctrl_if.sv - control, config and status bundle for the L1 PWM controller
interface axi_ohs_pwm_l1_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic                  update_req;
  logic [DATA_WIDTH-1:0] cfg_period;
  logic [DATA_WIDTH-1:0] cfg_comparator;
  logic [DATA_WIDTH-1:0] cfg_burst;
  logic                  pwm_out;
  logic [DATA_WIDTH-1:0] pwm_counter;
  logic                  period_start;
  logic                  update_ack;
  logic                  burst_done;
  logic                  busy;
  logic                  cfg_error;

  modport master (
    output enable, update_req, cfg_period, cfg_comparator, cfg_burst,
    input  pwm_out, pwm_counter, period_start, update_ack, burst_done, busy, cfg_error
  );

  modport slave (
    input  enable, update_req, cfg_period, cfg_comparator, cfg_burst,
    output pwm_out, pwm_counter, period_start, update_ack, burst_done, busy, cfg_error
  );
endinterface

// File: rtl/axi_ohs_pwm_l1_ctrl.sv
// rtl/axi_ohs_pwm_l1_ctrl.sv - PWM sequencer with double-buffered config applied at period boundaries
module axi_ohs_pwm_l1_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  axi_ohs_pwm_l1_ctrl_if.slave  ctrl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] counter_q, counter_d;
  logic [DATA_WIDTH-1:0] shadow_period_q, shadow_period_d;
  logic [DATA_WIDTH-1:0] shadow_comparator_q, shadow_comparator_d;
  logic [DATA_WIDTH-1:0] shadow_burst_q, shadow_burst_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] active_period_q, active_period_d;
  logic [DATA_WIDTH-1:0] active_comparator_q, active_comparator_d;
  logic [DATA_WIDTH-1:0] active_burst_q, active_burst_d;
  logic [DATA_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic                  pwm_q, pwm_d;
  logic                  period_start_q, period_start_d;
  logic                  update_ack_q, update_ack_d;
  logic                  burst_done_q, burst_done_d;
  logic                  cfg_error_q, cfg_error_d;
  logic                  wrap;
  logic                  apply_now;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q             <= IDLE;
      counter_q           <= '0;
      shadow_period_q     <= '0;
      shadow_comparator_q <= '0;
      shadow_burst_q      <= '0;
      pending_q           <= 1'b0;
      active_period_q     <= '0;
      active_comparator_q <= '0;
      active_burst_q      <= '0;
      burst_cnt_q         <= '0;
      pwm_q               <= 1'b0;
      period_start_q      <= 1'b0;
      update_ack_q        <= 1'b0;
      burst_done_q        <= 1'b0;
      cfg_error_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      counter_q           <= counter_d;
      shadow_period_q     <= shadow_period_d;
      shadow_comparator_q <= shadow_comparator_d;
      shadow_burst_q      <= shadow_burst_d;
      pending_q           <= pending_d;
      active_period_q     <= active_period_d;
      active_comparator_q <= active_comparator_d;
      active_burst_q      <= active_burst_d;
      burst_cnt_q         <= burst_cnt_d;
      pwm_q               <= pwm_d;
      period_start_q      <= period_start_d;
      update_ack_q        <= update_ack_d;
      burst_done_q        <= burst_done_d;
      cfg_error_q         <= cfg_error_d;
    end
  end

  assign wrap = (counter_q == active_period_q - DATA_WIDTH'(1));

  always_comb begin
    state_d             = state_q;
    counter_d           = counter_q;
    shadow_period_d     = shadow_period_q;
    shadow_comparator_d = shadow_comparator_q;
    shadow_burst_d      = shadow_burst_q;
    pending_d           = pending_q;
    active_period_d     = active_period_q;
    active_comparator_d = active_comparator_q;
    active_burst_d      = active_burst_q;
    burst_cnt_d         = burst_cnt_q;
    update_ack_d        = 1'b0;
    burst_done_d        = 1'b0;
    cfg_error_d         = cfg_error_q;
    apply_now           = 1'b0;

    case (state_q)
      IDLE: begin
        counter_d = '0;
        // A pending or in-flight capture is settled before any start decision.
        if (pending_q) begin
          apply_now = 1'b1;
        end else if (ctrl.enable && !ctrl.update_req) begin
          if (active_period_q != '0) begin
            state_d     = RUN;
            burst_cnt_d = active_burst_q;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      RUN, DRAIN: begin
        if (wrap) begin
          counter_d = '0;
          apply_now = pending_q;
          if (burst_cnt_q != '0) begin
            burst_cnt_d = burst_cnt_q - DATA_WIDTH'(1);
            if (burst_cnt_q == DATA_WIDTH'(1)) begin
              burst_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = ctrl.enable ? RUN : IDLE;
          end
        end else begin
          counter_d = counter_q + DATA_WIDTH'(1);
          // A burst runs to completion regardless of enable.
          if (burst_cnt_q == '0) begin
            state_d = ctrl.enable ? RUN : DRAIN;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase

    if (apply_now) begin
      pending_d = 1'b0;
      if (shadow_period_q == '0) begin
        cfg_error_d = 1'b1;
      end else begin
        active_period_d     = shadow_period_q;
        active_comparator_d = shadow_comparator_q;
        active_burst_d      = shadow_burst_q;
        update_ack_d        = 1'b1;
      end
    end

    // Capture after apply so a same-cycle request waits for the next boundary.
    if (ctrl.update_req) begin
      shadow_period_d     = ctrl.cfg_period;
      shadow_comparator_d = ctrl.cfg_comparator;
      shadow_burst_d      = ctrl.cfg_burst;
      pending_d           = 1'b1;
    end
  end

  always_comb begin
    pwm_d          = (state_d != IDLE) && (counter_d < active_comparator_d);
    period_start_d = (state_d == RUN) && (counter_d == '0);
  end

  assign ctrl.pwm_out      = pwm_q;
  assign ctrl.pwm_counter  = counter_q;
  assign ctrl.period_start = period_start_q;
  assign ctrl.update_ack   = update_ack_q;
  assign ctrl.burst_done   = burst_done_q;
  assign ctrl.busy         = (state_q != IDLE);
  assign ctrl.cfg_error    = cfg_error_q;

endmodule

// File: tb/tb_axi_ohs_pwm_l1_ctrl.sv
// tb/tb_axi_ohs_pwm_l1_ctrl.sv - scoreboard bench for the L1 PWM sequencer
module tb_axi_ohs_pwm_l1_ctrl;

  logic s_axi_aclk = 1'b0;
  logic s_axi_areset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] cnt;
    logic        pwm;
    logic        ps;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];

  axi_ohs_pwm_l1_ctrl_if #(.DATA_WIDTH(32)) ifc ();

  axi_ohs_pwm_l1_ctrl #(.DATA_WIDTH(32)) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_areset (s_axi_areset),
    .ctrl         (ifc)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic push_period(input int p, input int c, input bit ack_first);
    for (int k = 0; k < p; k++) begin
      exp_t e;
      e.cnt = k;
      e.pwm = (k < c);
      e.ps  = (k == 0);
      e.ack = ack_first && (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain_sb(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
        return;
      end
      e = exp_q.pop_front();
      chk("cnt", ifc.pwm_counter, e.cnt);
      chk("pwm", ifc.pwm_out, e.pwm);
      chk("period_start", ifc.period_start, e.ps);
      chk("update_ack", ifc.update_ack, e.ack);
      chk("busy", ifc.busy, 1);
      chk("burst_done", ifc.burst_done, 0);
      tick();
    end
  endtask

  task automatic start_cfg(input int p, input int c, input int b);
    ifc.enable         = 1'b0;
    ifc.update_req     = 1'b1;
    ifc.cfg_period     = p;
    ifc.cfg_comparator = c;
    ifc.cfg_burst      = b;
    tick();
    ifc.update_req = 1'b0;
    tick();
    chk("start_ack", ifc.update_ack, 1);
    ifc.enable = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (ifc.busy && n < bound) begin
      tick();
      n++;
    end
    chk("idle_busy", ifc.busy, 0);
    chk("idle_pwm", ifc.pwm_out, 0);
    chk("idle_cnt", ifc.pwm_counter, 0);
  endtask

  task automatic stop();
    ifc.enable = 1'b0;
    wait_idle(40);
  endtask

  initial begin
    ifc.enable         = 1'b0;
    ifc.update_req     = 1'b0;
    ifc.cfg_period     = '0;
    ifc.cfg_comparator = '0;
    ifc.cfg_burst      = '0;
    repeat (2) @(posedge s_axi_aclk);
    #1;
    chk("rst_pwm", ifc.pwm_out, 0);
    chk("rst_cnt", ifc.pwm_counter, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_ps", ifc.period_start, 0);
    chk("rst_ack", ifc.update_ack, 0);
    chk("rst_err", ifc.cfg_error, 0);
    s_axi_areset = 1'b0;

    // 10/3 continuous: ack the cycle after capture, RUN one cycle after ack.
    ifc.update_req     = 1'b1;
    ifc.cfg_period     = 10;
    ifc.cfg_comparator = 3;
    ifc.cfg_burst      = 0;
    ifc.enable         = 1'b1;
    tick();
    ifc.update_req = 1'b0;
    chk("s1_ack_early", ifc.update_ack, 0);
    chk("s1_busy_early", ifc.busy, 0);
    tick();
    chk("s1_ack", ifc.update_ack, 1);
    chk("s1_busy_ack", ifc.busy, 0);
    tick();
    push_period(10, 3, 0);
    push_period(10, 3, 0);
    push_period(10, 3, 0);
    drain_sb(30);

    // Mid-period update to 20/15 lands on the wrap.
    push_period(10, 3, 0);
    push_period(20, 15, 1);
    push_period(20, 15, 0);
    drain_sb(4);
    ifc.update_req     = 1'b1;
    ifc.cfg_period     = 20;
    ifc.cfg_comparator = 15;
    drain_sb(1);
    ifc.update_req = 1'b0;
    drain_sb(45);

    // Drop enable at counter 0: drain the whole period then idle.
    ifc.enable = 1'b0;
    push_period(20, 15, 0);
    drain_sb(20);
    wait_idle(1);

    // 8/4: drop at counter 2 drains to 7.
    start_cfg(8, 4, 0);
    push_period(8, 4, 0);
    drain_sb(2);
    ifc.enable = 1'b0;
    drain_sb(6);
    wait_idle(1);

    // Re-raise at counter 5 continues without a break.
    ifc.enable = 1'b1;
    tick();
    push_period(8, 4, 0);
    push_period(8, 4, 0);
    drain_sb(2);
    ifc.enable = 1'b0;
    drain_sb(3);
    ifc.enable = 1'b1;
    drain_sb(11);
    stop();

    // Burst of 3 periods at 4/2 from a one-cycle enable pulse.
    start_cfg(4, 2, 3);
    ifc.enable = 1'b0;
    push_period(4, 2, 0);
    push_period(4, 2, 0);
    push_period(4, 2, 0);
    drain_sb(12);
    chk("burst_done", ifc.burst_done, 1);
    chk("burst_idle", ifc.busy, 0);
    chk("burst_pwm", ifc.pwm_out, 0);
    tick();
    chk("burst_done_once", ifc.burst_done, 0);

    // Period 0 update is rejected and active config survives.
    ifc.update_req     = 1'b1;
    ifc.cfg_period     = 0;
    ifc.cfg_comparator = 5;
    ifc.cfg_burst      = 0;
    tick();
    ifc.update_req = 1'b0;
    tick();
    chk("p0_ack", ifc.update_ack, 0);
    chk("p0_err", ifc.cfg_error, 1);
    ifc.enable = 1'b1;
    tick();
    ifc.enable = 1'b0;
    push_period(4, 2, 0);
    push_period(4, 2, 0);
    push_period(4, 2, 0);
    drain_sb(12);
    chk("p0_burst_done", ifc.burst_done, 1);

    // Enable from reset with no valid period.
    s_axi_areset = 1'b1;
    tick();
    chk("rst2_err", ifc.cfg_error, 0);
    s_axi_areset = 1'b0;
    ifc.enable = 1'b1;
    tick();
    tick();
    chk("en_p0_busy", ifc.busy, 0);
    chk("en_p0_err", ifc.cfg_error, 1);
    ifc.enable = 1'b0;

    // Comparator edges and period 1.
    start_cfg(6, 0, 0);
    push_period(6, 0, 0);
    push_period(6, 0, 0);
    drain_sb(12);
    stop();
    start_cfg(10, 12, 0);
    push_period(10, 12, 0);
    push_period(10, 12, 0);
    drain_sb(20);
    stop();
    start_cfg(1, 1, 0);
    for (int i = 0; i < 5; i++) push_period(1, 1, 0);
    drain_sb(5);
    stop();

    // Asynchronous reset while pwm_out is high.
    start_cfg(10, 3, 0);
    push_period(10, 3, 0);
    drain_sb(2);
    exp_q.delete();
    chk("pre_rst_pwm", ifc.pwm_out, 1);
    #2;
    s_axi_areset = 1'b1;
    #1;
    chk("async_pwm", ifc.pwm_out, 0);
    chk("async_cnt", ifc.pwm_counter, 0);
    chk("async_busy", ifc.busy, 0);
    chk("async_ps", ifc.period_start, 0);

    chk("sb_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
